// File: rtl/display_scan_if.sv
// ============================================================================
//  Module   : display_scan_if
//  Brief    : Code/control inputs and scan outputs of the multiplexed display.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface display_scan_if #(
  parameter int DIGITS = 8,
  parameter int CODE_W = 5
);
  localparam int NUM_W = $clog2(DIGITS);

  logic                     load;
  logic [DIGITS*CODE_W-1:0] dig_in;
  logic [DIGITS-1:0]        blank_in;
  logic [DIGITS-1:0]        blink_in;
  logic [3:0]               bright;
  logic [DIGITS-1:0]        an;
  logic [CODE_W-1:0]        code;
  logic [NUM_W-1:0]         num;
  logic                     frame_done;

  modport master (
    output load, dig_in, blank_in, blink_in, bright,
    input  an, code, num, frame_done
  );

  modport slave (
    input  load, dig_in, blank_in, blink_in, bright,
    output an, code, num, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/display_scan.sv
// ============================================================================
//  Module   : display_scan
//  Brief    : Double-buffered common-anode 7-segment scanner with blanking,
//             blinking, PWM brightness and one dead cycle per slot.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module display_scan #(
  parameter int DIGITS       = 8,
  parameter int CODE_W       = 5,
  parameter int SCAN_DIV     = 1024,
  parameter int BLINK_FRAMES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  display_scan_if.slave bus
);

  localparam int NUM_W = $clog2(DIGITS);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int TH_W  = DIV_W + 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [NUM_W-1:0] c_IDX_LAST = NUM_W'(DIGITS - 1);
  localparam logic [FRM_W-1:0] c_FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [TH_W-1:0]  c_STEP     = TH_W'(SCAN_DIV / 16);

  // Scan timing state
  logic [DIV_W-1:0] r_div_cnt;
  logic [NUM_W-1:0] r_idx;
  logic [FRM_W-1:0] r_frm_cnt;
  logic             r_blink_ph;
  logic [3:0]       r_bright_s;

  // Shadow / active register banks
  logic                     r_pending;
  logic [DIGITS*CODE_W-1:0] r_sh_code;
  logic [DIGITS-1:0]        r_sh_blank;
  logic [DIGITS-1:0]        r_sh_blink;
  logic [DIGITS*CODE_W-1:0] r_act_code;
  logic [DIGITS-1:0]        r_act_blank;
  logic [DIGITS-1:0]        r_act_blink;

  // Registered outputs
  logic [DIGITS-1:0] r_an;
  logic [CODE_W-1:0] r_code;
  logic [NUM_W-1:0]  r_num;
  logic              r_frame_done;

  logic              w_slot_end;
  logic              w_frame_end;
  logic [TH_W-1:0]   w_thresh;
  logic              w_lit;
  logic [CODE_W-1:0] w_cur_code;
  logic [DIGITS-1:0] w_an_lit;

  always_comb begin
    w_slot_end  = (r_div_cnt == c_DIV_LAST);
    w_frame_end = w_slot_end && (r_idx == c_IDX_LAST);
    w_thresh    = (TH_W'(r_bright_s) + TH_W'(1)) * c_STEP;
    w_lit       = !r_act_blank[r_idx]
                  && !(r_act_blink[r_idx] && r_blink_ph)
                  && (r_div_cnt != '0)
                  && ({1'b0, r_div_cnt} < w_thresh);
    w_an_lit    = ~(DIGITS'(1) << r_idx);
    w_cur_code  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == NUM_W'(k)) begin
        w_cur_code = r_act_code[k*CODE_W +: CODE_W];
      end
    end
  end

  // Prescaler, slot index, blink frame counter and per-slot brightness sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt  <= '0;
      r_idx      <= '0;
      r_frm_cnt  <= '0;
      r_blink_ph <= 1'b0;
      r_bright_s <= '0;
    end else begin
      if (r_div_cnt == '0) begin
        r_bright_s <= bus.bright;
      end
      if (w_slot_end) begin
        r_div_cnt <= '0;
        r_idx     <= (r_idx == c_IDX_LAST) ? '0 : r_idx + NUM_W'(1);
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
      if (w_frame_end) begin
        if (r_frm_cnt == c_FRM_LAST) begin
          r_frm_cnt  <= '0;
          r_blink_ph <= ~r_blink_ph;
        end else begin
          r_frm_cnt <= r_frm_cnt + FRM_W'(1);
        end
      end
    end
  end

  // Active bank only changes on the frame boundary so a frame never mixes data;
  // a load on the boundary itself bypasses the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= 1'b0;
      r_sh_code   <= '0;
      r_sh_blank  <= '1;
      r_sh_blink  <= '0;
      r_act_code  <= '0;
      r_act_blank <= '1;
      r_act_blink <= '0;
    end else begin
      if (bus.load) begin
        r_sh_code  <= bus.dig_in;
        r_sh_blank <= bus.blank_in;
        r_sh_blink <= bus.blink_in;
      end
      if (w_frame_end) begin
        r_pending <= 1'b0;
        if (bus.load) begin
          r_act_code  <= bus.dig_in;
          r_act_blank <= bus.blank_in;
          r_act_blink <= bus.blink_in;
        end else if (r_pending) begin
          r_act_code  <= r_sh_code;
          r_act_blank <= r_sh_blank;
          r_act_blink <= r_sh_blink;
        end
      end else if (bus.load) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an         <= '1;
      r_code       <= '0;
      r_num        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_lit ? w_an_lit : '1;
      r_code       <= w_lit ? w_cur_code : '0;
      r_num        <= r_idx;
      r_frame_done <= w_frame_end;
    end
  end

  assign bus.an         = r_an;
  assign bus.code       = r_code;
  assign bus.num        = r_num;
  assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_display_scan.sv
// ============================================================================
//  Module   : tb_display_scan
//  Brief    : Directed self-checking bench for display_scan (4 digits,
//             16-cycle slots, 2-frame blink half-period).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_display_scan;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_scan_if #(.DIGITS(4), .CODE_W(5)) bus ();

  display_scan #(
    .DIGITS(4), .CODE_W(5), .SCAN_DIV(16), .BLINK_FRAMES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  localparam logic [19:0] CODES_A  = {5'h1F, 5'h0A, 5'h05, 5'h11};
  localparam logic [19:0] CODES_T1 = {5'h01, 5'h02, 5'h03, 5'h04};
  localparam logic [19:0] CODES_T2 = {5'h08, 5'h09, 5'h0C, 5'h0E};
  localparam logic [19:0] CODES_D  = {5'h15, 5'h16, 5'h17, 5'h18};
  localparam logic [19:0] CODES_C  = {5'h1A, 5'h1B, 5'h1C, 5'h1D};
  localparam logic [19:0] CODES_E  = {5'h06, 5'h07, 5'h0D, 5'h13};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // rising edges since reset release

  // Expected {an, code, num, frame_done} for the outputs after edge 'cyc'
  function automatic logic [11:0] exp_out(input logic [19:0] codes,
                                          input logic [3:0]  blank,
                                          input logic [3:0]  blink,
                                          input int          br);
    int d, s, f;
    logic lit;
    logic [3:0] a;
    logic [4:0] c;
    d   = (cyc - 1) % 16;
    s   = ((cyc - 1) / 16) % 4;
    f   = (cyc - 1) / 64;
    lit = !blank[s] && !(blink[s] && ((f / 2) % 2 == 1)) && (d != 0) && (d < br + 1);
    a   = lit ? ~(4'd1 << s) : 4'hF;
    c   = lit ? codes[s*5 +: 5] : 5'd0;
    return {a, c, 2'(s), (d == 15 && s == 3)};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    bus.load = 1'b0;
  endtask

  task automatic drive_load(input logic [19:0] codes, input logic [3:0] blank,
                            input logic [3:0] blink);
    bus.dig_in   = codes;
    bus.blank_in = blank;
    bus.blink_in = blink;
    bus.load     = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    int fd_cnt;
    fd_cnt       = 0;
    bus.load     = 1'b0;
    bus.dig_in   = '0;
    bus.blank_in = '0;
    bus.blink_in = '0;
    bus.bright   = 4'd15;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.an, bus.code, bus.num, bus.frame_done} !== 12'hF00) begin
      errors++;
      $display("FAIL reset_values got=%h exp=%h", {bus.an, bus.code, bus.num, bus.frame_done}, 12'hF00);
    end
    rst_n = 1'b1;
    cyc   = 0;
    repeat (200) begin
      tick();
      exp = exp_out(20'd0, 4'hF, 4'h0, 15);
      if (bus.frame_done === 1'b1) fd_cnt++;
      checks++;
      if ({bus.an, bus.code, bus.num, bus.frame_done} !== exp) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, {bus.an, bus.code, bus.num, bus.frame_done}, exp);
      end
    end
    checks++;
    if (fd_cnt !== 3) begin
      errors++;
      $display("FAIL frame_done_count got=%0d exp=3", fd_cnt);
    end
  endtask

  task automatic test_basic_scan();
    logic [11:0] exp;
    while (cyc < 320) begin
      if (cyc == 200) drive_load(CODES_A, 4'h0, 4'h0);
      tick();
      if (cyc == 201) begin
        checks++;
        if (dut.r_pending !== 1'b1) begin
          errors++;
          $display("FAIL pending_set got=%b exp=1", dut.r_pending);
        end
      end
      exp = ((cyc - 1) / 64 < 4) ? exp_out(20'd0, 4'hF, 4'h0, 15)
                                 : exp_out(CODES_A, 4'h0, 4'h0, 15);
      checks++;
      if ({bus.an, bus.code, bus.num, bus.frame_done} !== exp) begin
        errors++;
        $display("FAIL basic_scan cyc=%0d got=%h exp=%h", cyc, {bus.an, bus.code, bus.num, bus.frame_done}, exp);
      end
    end
  endtask

  task automatic test_brightness();
    logic [11:0] exp;
    int lit_cnt;
    lit_cnt    = 0;
    bus.bright = 4'd3;
    while (cyc < 384) begin
      tick();
      exp = exp_out(CODES_A, 4'h0, 4'h0, 3);
      if (bus.an !== 4'hF) lit_cnt++;
      checks++;
      if ({bus.an, bus.code, bus.num, bus.frame_done} !== exp) begin
        errors++;
        $display("FAIL brightness cyc=%0d got=%h exp=%h", cyc, {bus.an, bus.code, bus.num, bus.frame_done}, exp);
      end
    end
    checks++;
    if (lit_cnt !== 12) begin
      errors++;
      $display("FAIL bright_lit_count got=%0d exp=12", lit_cnt);
    end
  endtask

  task automatic test_tear_free();
    logic [11:0] exp;
    bus.bright = 4'd15;
    while (cyc < 512) begin
      if (cyc == 404) drive_load(CODES_T1, 4'h0, 4'h0);
      if (cyc == 419) drive_load(CODES_T2, 4'h0, 4'h0);
      tick();
      if (cyc == 420) begin
        checks++;
        if (dut.r_pending !== 1'b1) begin
          errors++;
          $display("FAIL tear_pending got=%b exp=1", dut.r_pending);
        end
      end
      exp = ((cyc - 1) / 64 == 6) ? exp_out(CODES_A, 4'h0, 4'h0, 15)
                                  : exp_out(CODES_T2, 4'h0, 4'h0, 15);
      checks++;
      if ({bus.an, bus.code, bus.num, bus.frame_done} !== exp) begin
        errors++;
        $display("FAIL tear_free cyc=%0d got=%h exp=%h", cyc, {bus.an, bus.code, bus.num, bus.frame_done}, exp);
      end
    end
  endtask

  task automatic test_boundary_blink();
    logic [11:0] exp;
    while (cyc < 832) begin
      if (cyc == 529) drive_load(CODES_D, 4'h0, 4'h0);
      if (cyc == 575) drive_load(CODES_C, 4'h0, 4'b0100);
      tick();
      if (cyc == 530 || cyc == 576) begin
        checks++;
        if (dut.r_pending !== (cyc == 530)) begin
          errors++;
          $display("FAIL boundary_pending cyc=%0d got=%b exp=%b", cyc, dut.r_pending, (cyc == 530));
        end
      end
      exp = ((cyc - 1) / 64 == 8) ? exp_out(CODES_T2, 4'h0, 4'h0, 15)
                                  : exp_out(CODES_C, 4'h0, 4'b0100, 15);
      checks++;
      if ({bus.an, bus.code, bus.num, bus.frame_done} !== exp) begin
        errors++;
        $display("FAIL boundary_blink cyc=%0d got=%h exp=%h", cyc, {bus.an, bus.code, bus.num, bus.frame_done}, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp;
    while (cyc < 870) begin
      tick();
      exp = exp_out(CODES_C, 4'h0, 4'b0100, 15);
      checks++;
      if ({bus.an, bus.code, bus.num, bus.frame_done} !== exp) begin
        errors++;
        $display("FAIL pre_reset cyc=%0d got=%h exp=%h", cyc, {bus.an, bus.code, bus.num, bus.frame_done}, exp);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.an, bus.code, bus.num, bus.frame_done} !== 12'hF00) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", {bus.an, bus.code, bus.num, bus.frame_done}, 12'hF00);
    end
    drive_load(CODES_E, 4'h0, 4'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.load = 1'b0;
    checks++;
    if ({bus.an, bus.code, bus.num, bus.frame_done} !== 12'hF00) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=%h", {bus.an, bus.code, bus.num, bus.frame_done}, 12'hF00);
    end
    rst_n = 1'b1;
    cyc   = 0;
    while (cyc < 128) begin
      if (cyc == 10) drive_load(CODES_E, 4'h0, 4'h0);
      tick();
      exp = ((cyc - 1) / 64 == 0) ? exp_out(20'd0, 4'hF, 4'h0, 15)
                                  : exp_out(CODES_E, 4'h0, 4'h0, 15);
      checks++;
      if ({bus.an, bus.code, bus.num, bus.frame_done} !== exp) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, {bus.an, bus.code, bus.num, bus.frame_done}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_brightness();
    test_tear_free();
    test_boundary_blink();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
